wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//  Parametrised Wishbone B4 classic master between the CPU load/store unit and the system bus.
//  Supports B/H/W loads and stores, and bus widths of 32 or 64 bits.
//  Steers byte lanes from the low address bits and sign/zero-extends read data.
//  Adds bus-error, timeout and misalignment reporting via an explicit accept/done handshake.
// PARAMETERS
//  ADDR_W   32  byte-address width of I_addr / ADR_O
//  DATA_W   32  Wishbone data width; legal values 32 or 64; SEL_W = DATA_W/8, OFS_W = log2(SEL_W)
//  TIMEOUT  255 cycles in BUS without ACK_I/ERR_I before abort; 0 disables the timeout
// PORTS
//  CLK_I    in   1       clock; all state on posedge
//  RST_I    in   1       asynchronous, active-low reset
//  I_req    in   1       request valid; sampled only in IDLE
//  I_op     in   4       `BUSOP_* code from cpu/busdefs.vh (READB/BU/H/HU/W, WRITEB/H/W)
//  I_addr   in   ADDR_W  byte address
//  I_data   in   32      store data, right-aligned
//  O_busy   out  1       high from the accept cycle+1 through the cycle before O_done
//  O_done   out  1       one-cycle pulse: transfer finished; O_data/O_err valid this cycle
//  O_data   out  32      load result, extended; holds until the next O_done
//  O_err    out  2       00 ok, 01 bus ERR_I, 10 timeout, 11 misaligned; valid with O_done
//  ACK_I    in   1       slave acknowledge
//  ERR_I    in   1       slave error
//  DAT_I    in   DATA_W  read data
//  ADR_O    out  ADDR_W  I_addr with the low OFS_W bits cleared
//  DAT_O    out  DATA_W  store data shifted into its lanes
//  SEL_O    out  SEL_W   byte enables
//  CYC_O    out  1       bus cycle
//  STB_O    out  1       strobe; always equal to CYC_O
//  WE_O     out  1       write enable
// BEHAVIOUR
//  Reset (RST_I=0, asynchronous): state=IDLE; these outputs are 0:
//   CYC_O, STB_O, WE_O, SEL_O, ADR_O, DAT_O, O_busy, O_done, O_data, O_err; timeout counter cleared.
//   Reset mid-transfer drops CYC_O immediately and produces no O_done.
//  FSM states: IDLE, BUS, DONE.
//  IDLE:
//   - I_req=1 -> compute size (B=1, H=2, W=4 bytes) and ofs = I_addr[OFS_W-1:0].
//   - Misaligned when (size=2 and ofs[0]) or (size=4 and ofs[1:0]!=0): next state DONE, O_err=11,
//     no bus cycle, O_data unchanged.
//   - Otherwise next state BUS, registering:
//     ADR_O = aligned address; SEL_O = (size mask) << ofs; DAT_O = I_data << (8*ofs);
//     WE_O = store; CYC_O = STB_O = 1; O_busy = 1.
//  BUS:
//   - Counter increments each cycle.
//   - Priority: ERR_I > ACK_I > timeout.
//   - On ERR_I: O_err=01.
//   - On ACK_I: O_err=00; for reads, O_data = extend((DAT_I >> 8*ofs)[8*size-1:0]),
//     sign-extended for READB/READH, zero-extended otherwise (READW passes through).
//   - On counter==TIMEOUT (TIMEOUT!=0): O_err=10.
//   - Any of the three ends the transfer: next state DONE; CYC_O, STB_O, WE_O, SEL_O -> 0; O_busy -> 0.
//   - Write-data loads never change O_data.
//  DONE: O_done=1 for exactly one cycle, then IDLE; I_req is ignored during DONE.
//  Latency: req accepted at edge N -> CYC_O high after N; ACK_I sampled at edge M -> CYC_O low and
//   O_done high after M. Single-cycle ACK yields accept-to-done = 2 cycles.
//  ACK_I/ERR_I outside BUS are ignored. ADR_O/DAT_O hold their last value when idle.
//  I_op with an unknown code is treated as READW.
//  With DATA_W=64, the word lane uses ofs[2]: SEL_O=8'hF0 when ofs=4.
// TESTING
//  1 DATA_W=32, READB addr 0x1003, DAT_I=0x80xxxxxx, ACK next cycle ->
//    SEL_O=4'b1000, ADR_O=0x1000, O_data=0xFFFFFF80, O_err=00, accept-to-done 2 cycles.
//  2 WRITEH addr 0x2002, I_data=0x0000BEEF ->
//    SEL_O=4'b1100, DAT_O=0xBEEF0000, WE_O=1; READHU of same lane with DAT_I=0xBEEF0000 -> O_data=0x0000BEEF.
//  3 READW addr 0x3001 -> no CYC_O ever; O_done one cycle after accept; O_err=11.
//  4 TIMEOUT=8, slave never responds -> CYC_O high exactly 8 cycles, then O_done with O_err=10.
//  5 ACK_I and ERR_I asserted in the same cycle -> O_err=01, O_data unchanged; I_req held high during
//    DONE -> new transfer starts only after IDLE.
//  6 DATA_W=64, WRITEW addr 0x4004, I_data=0x11223344 -> SEL_O=8'hF0, DAT_O[63:32]=0x11223344;
//    RST_I low mid-BUS -> CYC_O=0 asynchronously, no O_done.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic master for the load/store unit: B/H/W loads and stores with byte-lane
// steering, read-data extension, and ERR/timeout/misalignment status on a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for I_req; ACK_I/ERR_I ignored
// BUS   | CYC_O/STB_O high, waiting for ERR_I, ACK_I or timeout
// DONE  | O_done pulse; O_data/O_err valid; I_req ignored
module wb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                I_req,
  input  logic [3:0]          I_op,
  input  logic [ADDR_W-1:0]   I_addr,
  input  logic [31:0]         I_data,
  output logic                O_busy,
  output logic                O_done,
  output logic [31:0]         O_data,
  output logic [1:0]          O_err,
  input  logic                ACK_I,
  input  logic                ERR_I,
  input  logic [DATA_W-1:0]   DAT_I,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFS_W = $clog2(SEL_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [3:0] BUSOP_READB  = 4'd0;
  localparam logic [3:0] BUSOP_READBU = 4'd1;
  localparam logic [3:0] BUSOP_READH  = 4'd2;
  localparam logic [3:0] BUSOP_READHU = 4'd3;
  localparam logic [3:0] BUSOP_READW  = 4'd4;
  localparam logic [3:0] BUSOP_WRITEB = 4'd8;
  localparam logic [3:0] BUSOP_WRITEH = 4'd9;
  localparam logic [3:0] BUSOP_WRITEW = 4'd10;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_MIS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        size_r, size_n;
  logic              sgn_r, sgn_n;
  logic [OFS_W-1:0]  ofs_r, ofs_n;
  logic [ADDR_W-1:0] adr_n;
  logic [DATA_W-1:0] dat_n;
  logic [SEL_W-1:0]  sel_n;
  logic              we_n;
  logic [31:0]       data_n;
  logic [1:0]        err_n;

  logic [1:0]        req_size;
  logic              req_sgn;
  logic              req_we;
  logic              req_mis;
  logic [3:0]        req_mask;
  logic [OFS_W-1:0]  req_ofs;
  logic [31:0]       lane;
  logic [31:0]       rd_ext;
  logic              timeout_hit;

  assign req_ofs = I_addr[OFS_W-1:0];

  // Unknown opcodes fall through to the READW defaults.
  always_comb begin
    req_size = SZ_W;
    req_sgn  = 1'b0;
    req_we   = 1'b0;
    case (I_op)
      BUSOP_READB:  begin req_size = SZ_B; req_sgn = 1'b1; end
      BUSOP_READBU: req_size = SZ_B;
      BUSOP_READH:  begin req_size = SZ_H; req_sgn = 1'b1; end
      BUSOP_READHU: req_size = SZ_H;
      BUSOP_READW:  req_size = SZ_W;
      BUSOP_WRITEB: begin req_size = SZ_B; req_we = 1'b1; end
      BUSOP_WRITEH: begin req_size = SZ_H; req_we = 1'b1; end
      BUSOP_WRITEW: req_we = 1'b1;
      default:      req_size = SZ_W;
    endcase
  end

  always_comb begin
    req_mask = 4'b1111;
    case (req_size)
      SZ_B:    req_mask = 4'b0001;
      SZ_H:    req_mask = 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  assign req_mis = ((req_size == SZ_H) && req_ofs[0]) ||
                   ((req_size == SZ_W) && (req_ofs[1:0] != 2'b00));

  assign lane = 32'(DAT_I >> {ofs_r, 3'b000});

  always_comb begin
    rd_ext = lane;
    case (size_r)
      SZ_B:    rd_ext = {{24{sgn_r & lane[7]}}, lane[7:0]};
      SZ_H:    rd_ext = {{16{sgn_r & lane[15]}}, lane[15:0]};
      default: rd_ext = lane;
    endcase
  end

  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    size_n  = size_r;
    sgn_n   = sgn_r;
    ofs_n   = ofs_r;
    adr_n   = ADR_O;
    dat_n   = DAT_O;
    sel_n   = SEL_O;
    we_n    = WE_O;
    data_n  = O_data;
    err_n   = O_err;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (I_req) begin
          size_n = req_size;
          sgn_n  = req_sgn;
          ofs_n  = req_ofs;
          if (req_mis) begin
            state_n = S_DONE;
            err_n   = ERR_MIS;
          end else begin
            state_n = S_BUS;
            adr_n   = {I_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            sel_n   = SEL_W'(req_mask) << req_ofs;
            dat_n   = DATA_W'(I_data) << {req_ofs, 3'b000};
            we_n    = req_we;
          end
        end
      end
      S_BUS: begin
        cnt_n = cnt + CNT_W'(1);
        if (ERR_I || ACK_I || timeout_hit) begin
          state_n = S_DONE;
          cnt_n   = '0;
          sel_n   = '0;
          we_n    = 1'b0;
          if (ERR_I) begin
            err_n = ERR_BUS;
          end else if (ACK_I) begin
            err_n = ERR_OK;
            if (!WE_O) data_n = rd_ext;
          end else begin
            err_n = ERR_TO;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state  <= S_IDLE;
      cnt    <= '0;
      size_r <= SZ_W;
      sgn_r  <= 1'b0;
      ofs_r  <= '0;
      ADR_O  <= '0;
      DAT_O  <= '0;
      SEL_O  <= '0;
      WE_O   <= 1'b0;
      O_data <= '0;
      O_err  <= ERR_OK;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      size_r <= size_n;
      sgn_r  <= sgn_n;
      ofs_r  <= ofs_n;
      ADR_O  <= adr_n;
      DAT_O  <= dat_n;
      SEL_O  <= sel_n;
      WE_O   <= we_n;
      O_data <= data_n;
      O_err  <= err_n;
    end
  end

  // Bus strobes and busy are pure state decodes so reset drops them without a clock.
  assign CYC_O  = (state == S_BUS);
  assign STB_O  = CYC_O;
  assign O_busy = CYC_O;
  assign O_done = (state == S_DONE);

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: 32-bit and 64-bit instances run in lockstep against a
// size/offset arithmetic model, with directed vectors, random transfers and reset corners.
module tb_wb_master_bridge;

  localparam int TO = 8;

  localparam logic [3:0] OP_RB  = 4'd0;
  localparam logic [3:0] OP_RBU = 4'd1;
  localparam logic [3:0] OP_RH  = 4'd2;
  localparam logic [3:0] OP_RHU = 4'd3;
  localparam logic [3:0] OP_RW  = 4'd4;
  localparam logic [3:0] OP_WB  = 4'd8;
  localparam logic [3:0] OP_WH  = 4'd9;
  localparam logic [3:0] OP_WW  = 4'd10;
  localparam logic [3:0] OP_BAD = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n, req, ack, err;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic [63:0] dat_in;

  logic        busy32, done32, cyc32, stb32, we32;
  logic [31:0] od32, adr32, dato32;
  logic [1:0]  oe32;
  logic [3:0]  sel32;
  logic        busy64, done64, cyc64, stb64, we64;
  logic [31:0] od64, adr64;
  logic [63:0] dato64;
  logic [1:0]  oe64;
  logic [7:0]  sel64;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_od32, m_od64;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          resp;   // 0 ack, 1 err, 2 silent, 3 ack+err
    int          wt;
    logic [63:0] rd;
    logic [1:0]  x_err;
    logic [3:0]  x_sel32;
    logic [31:0] x_od32;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] ops [9];

  always #5 clk = ~clk;

  wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut32 (
    .CLK_I(clk), .RST_I(rst_n), .I_req(req), .I_op(op), .I_addr(addr), .I_data(wdata),
    .O_busy(busy32), .O_done(done32), .O_data(od32), .O_err(oe32),
    .ACK_I(ack), .ERR_I(err), .DAT_I(dat_in[31:0]),
    .ADR_O(adr32), .DAT_O(dato32), .SEL_O(sel32), .CYC_O(cyc32), .STB_O(stb32), .WE_O(we32)
  );

  wb_master_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut64 (
    .CLK_I(clk), .RST_I(rst_n), .I_req(req), .I_op(op), .I_addr(addr), .I_data(wdata),
    .O_busy(busy64), .O_done(done64), .O_data(od64), .O_err(oe64),
    .ACK_I(ack), .ERR_I(err), .DAT_I(dat_in),
    .ADR_O(adr64), .DAT_O(dato64), .SEL_O(sel64), .CYC_O(cyc64), .STB_O(stb64), .WE_O(we64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_size(input logic [3:0] o);
    case (o)
      OP_RB, OP_RBU, OP_WB: return 1;
      OP_RH, OP_RHU, OP_WH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] o);
    return (o == OP_WB) || (o == OP_WH) || (o == OP_WW);
  endfunction

  function automatic bit op_signed(input logic [3:0] o);
    return (o == OP_RB) || (o == OP_RH);
  endfunction

  function automatic int ofs_of(input int lanes, input logic [31:0] a);
    return int'(a % 32'(lanes));
  endfunction

  function automatic bit misaligned(input logic [3:0] o, input logic [31:0] a);
    return (a % 32'(op_size(o))) != 0;
  endfunction

  function automatic logic [63:0] m_sel(input int lanes, input logic [3:0] o, input logic [31:0] a);
    logic [63:0] m;
    m = (64'd1 << op_size(o)) - 64'd1;
    return m << ofs_of(lanes, a);
  endfunction

  function automatic logic [63:0] m_dat(input int lanes, input logic [31:0] d, input logic [31:0] a);
    logic [63:0] v;
    v = {32'd0, d} << (8 * ofs_of(lanes, a));
    if (lanes == 4) v = {32'd0, v[31:0]};
    return v;
  endfunction

  function automatic logic [31:0] m_adr(input int lanes, input logic [31:0] a);
    return a - 32'(ofs_of(lanes, a));
  endfunction

  function automatic logic [31:0] m_rd(input int lanes, input logic [3:0] o, input logic [31:0] a,
                                       input logic [63:0] bus);
    logic [63:0] b, v, mask;
    int nb;
    nb   = 8 * op_size(o);
    b    = (lanes == 4) ? {32'd0, bus[31:0]} : bus;
    v    = b >> (8 * ofs_of(lanes, a));
    mask = (64'd1 << nb) - 64'd1;
    v    = v & mask;
    if (op_signed(o) && v[nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic run_txn(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                         input int resp, input int wt, input logic [63:0] rd,
                         output logic [3:0] seen_sel);
    int n = 0;
    int cyc_hi = 0;
    int exp_n;
    logic [1:0] x_err;
    op = o; addr = a; wdata = d; dat_in = rd; ack = 1'b0; err = 1'b0; req = 1'b1;
    step();
    req = 1'b0;
    seen_sel = sel32;
    if (misaligned(o, a)) begin
      chk("mis_done", {done32, done64}, 2'b11);
      chk("mis_err32", oe32, 2'b11);
      chk("mis_err64", oe64, 2'b11);
      chk("mis_cyc", {cyc32, cyc64, busy32, busy64}, 0);
      chk("mis_data32", od32, m_od32);
      chk("mis_data64", od64, m_od64);
      step();
      chk("mis_done_clr", {done32, done64}, 0);
    end else begin
      chk("bus32", {cyc32, stb32, busy32, done32}, 4'b1110);
      chk("bus64", {cyc64, stb64, busy64, done64}, 4'b1110);
      chk("we", {we32, we64}, {op_store(o), op_store(o)});
      chk("sel32", sel32, m_sel(4, o, a));
      chk("sel64", sel64, m_sel(8, o, a));
      chk("adr32", adr32, m_adr(4, a));
      chk("adr64", adr64, m_adr(8, a));
      chk("dat32", dato32, m_dat(4, d, a));
      chk("dat64", dato64, m_dat(8, d, a));
      if (cyc32) cyc_hi = 1;
      for (int c = 1; c <= TO + 4; c++) begin
        if (resp != 2 && c == wt + 1) begin
          ack = (resp == 0) || (resp == 3);
          err = (resp == 1) || (resp == 3);
        end
        step();
        ack = 1'b0; err = 1'b0;
        if (done32) begin
          n = c;
          break;
        end
        if (cyc32) cyc_hi++;
      end
      x_err = (resp == 0) ? 2'b00 : (resp == 2) ? 2'b10 : 2'b01;
      exp_n = (resp == 2) ? TO : wt + 1;
      chk("latency", n, exp_n);
      chk("cyc_cycles", cyc_hi, exp_n);
      if (resp == 0 && !op_store(o)) begin
        m_od32 = m_rd(4, o, a, rd);
        m_od64 = m_rd(8, o, a, rd);
      end
      chk("done64", done64, 1);
      chk("err32", oe32, x_err);
      chk("err64", oe64, x_err);
      chk("data32", od32, m_od32);
      chk("data64", od64, m_od64);
      chk("end_ctl", {cyc32, stb32, busy32, we32, cyc64, stb64, busy64, we64}, 0);
      chk("end_sel", {sel32, sel64}, 0);
      step();
      chk("done_clr", {done32, done64}, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s;
    logic       seen;
    rst_n = 1'b1; req = 1'b0; ack = 1'b0; err = 1'b0;
    op = 4'd0; addr = '0; wdata = '0; dat_in = '0;
    m_od32 = '0; m_od64 = '0;
    ops = '{OP_RB, OP_RBU, OP_RH, OP_RHU, OP_RW, OP_WB, OP_WH, OP_WW, OP_BAD};

    vecs.push_back(vec_t'{OP_RB,  32'h1003, 32'h0,        0, 0, 64'h0000_0000_8012_3456, 2'd0, 4'b1000, 32'hFFFF_FF80});
    vecs.push_back(vec_t'{OP_WH,  32'h2002, 32'h0000_BEEF, 0, 1, 64'h0,                  2'd0, 4'b1100, 32'hFFFF_FF80});
    vecs.push_back(vec_t'{OP_RHU, 32'h2002, 32'h0,        0, 0, 64'h0000_0000_BEEF_0000, 2'd0, 4'b1100, 32'h0000_BEEF});
    vecs.push_back(vec_t'{OP_RW,  32'h3001, 32'h0,        0, 0, 64'h0,                  2'd3, 4'b0000, 32'h0000_BEEF});
    vecs.push_back(vec_t'{OP_RW,  32'h5000, 32'h0,        2, 0, 64'h0,                  2'd2, 4'b1111, 32'h0000_BEEF});
    vecs.push_back(vec_t'{OP_RH,  32'h6000, 32'h0,        3, 2, 64'h0000_0000_1234_8001, 2'd1, 4'b0011, 32'h0000_BEEF});
    vecs.push_back(vec_t'{OP_RH,  32'h6000, 32'h0,        0, 0, 64'h0000_0000_1234_8001, 2'd0, 4'b0011, 32'hFFFF_8001});
    vecs.push_back(vec_t'{OP_RW,  32'h7000, 32'h0,        0, 7, 64'h0000_0000_CAFE_F00D, 2'd0, 4'b1111, 32'hCAFE_F00D});
    vecs.push_back(vec_t'{OP_RB,  32'h7001, 32'h0,        1, 0, 64'h0,                  2'd1, 4'b0010, 32'hCAFE_F00D});
    vecs.push_back(vec_t'{OP_BAD, 32'h7002, 32'h0,        0, 0, 64'h0,                  2'd3, 4'b0000, 32'hCAFE_F00D});
    vecs.push_back(vec_t'{OP_BAD, 32'h8004, 32'h0,        0, 0, 64'h1111_2222_3333_4444, 2'd0, 4'b1111, 32'h3333_4444});
    vecs.push_back(vec_t'{OP_RBU, 32'h9002, 32'h0,        0, 0, 64'h0000_0000_00F1_0000, 2'd0, 4'b0100, 32'h0000_00F1});
    vecs.push_back(vec_t'{OP_WW,  32'h4004, 32'h1122_3344, 0, 0, 64'h0,                  2'd0, 4'b1111, 32'h0000_00F1});
    vecs.push_back(vec_t'{OP_RH,  32'h9003, 32'h0,        0, 0, 64'h0,                  2'd3, 4'b0000, 32'h0000_00F1});
    vecs.push_back(vec_t'{OP_WB,  32'hA001, 32'h0000_00AB, 1, 1, 64'h0,                  2'd1, 4'b0010, 32'h0000_00F1});

    #3 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {cyc32, stb32, we32, busy32, done32, cyc64, stb64, we64, busy64, done64}, 0);
    chk("rst_sel", {sel32, sel64}, 0);
    chk("rst_adr", {adr32, adr64}, 0);
    chk("rst_dat", {dato32, dato64[63:32]}, 0);
    chk("rst_data", {od32, od64}, 0);
    chk("rst_err", {oe32, oe64}, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].wt, vecs[i].rd, s);
      chk($sformatf("v%0d_err", i), oe32, vecs[i].x_err);
      chk($sformatf("v%0d_data", i), od32, vecs[i].x_od32);
      chk($sformatf("v%0d_sel", i), s, vecs[i].x_sel32);
    end

    // ACK/ERR while idle must not start or finish anything
    ack = 1'b1; err = 1'b1;
    step(); step();
    ack = 1'b0; err = 1'b0;
    chk("idle_ack_done", {done32, done64, cyc32, cyc64}, 0);
    chk("idle_ack_err", oe32, 2'b01);

    // I_req held high through DONE only restarts once back in IDLE
    op = OP_RW; addr = 32'hB000; wdata = '0; dat_in = 64'hDEAD_BEEF_0BAD_F00D; req = 1'b1;
    step();
    chk("hold_acc", {cyc32, cyc64}, 2'b11);
    ack = 1'b1;
    step();
    ack = 1'b0;
    m_od32 = 32'h0BAD_F00D; m_od64 = 32'h0BAD_F00D;
    chk("hold_done", {done32, done64}, 2'b11);
    chk("hold_data", {od32, od64}, {m_od32, m_od64});
    step();
    chk("hold_idle", {done32, cyc32, busy32, done64, cyc64}, 0);
    step();
    chk("hold_restart", {cyc32, cyc64}, 2'b11);
    req = 1'b0; ack = 1'b1;
    step();
    ack = 1'b0;
    chk("hold_done2", {done32, done64}, 2'b11);
    step();

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  o;
      logic [31:0] a;
      int          r, resp;
      o = ops[$urandom_range(0, 8)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(op_size(o)) - 32'd1);
      r = $urandom_range(0, 9);
      resp = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 3 : 2;
      run_txn(o, a, $urandom, resp, $urandom_range(0, 3), {$urandom, $urandom}, s);
    end

    // Reset in the middle of a 64-bit word store
    op = OP_WW; addr = 32'h4004; wdata = 32'h1122_3344; req = 1'b1;
    step();
    req = 1'b0;
    chk("c_sel64", sel64, 8'hF0);
    chk("c_dat64_hi", dato64[63:32], 32'h1122_3344);
    chk("c_we_cyc64", {we64, cyc64}, 2'b11);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_cyc", {cyc32, stb32, cyc64, stb64, busy32, busy64}, 0);
    chk("c_rst_sel", {sel32, sel64, we32, we64}, 0);
    chk("c_rst_bus", {adr32, dato64[63:32]}, 0);
    chk("c_rst_data", {od32, od64}, 0);
    m_od32 = '0; m_od64 = '0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) rst_n = 1'b1;
      if (done32 || done64) seen = 1'b1;
    end
    chk("c_no_done", seen, 0);
    run_txn(OP_RHU, 32'hC006, 32'h0, 0, 1, 64'h5A5A_0000_0000_0000, s);
    chk("c_recover_sel", s, 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
